// File: rtl/fc_sequencer.sv
// fc_sequencer: time-multiplexed fully-connected layer controller around one 16x16 MAC.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start / busy / done    run handshake with the network controller
//   in_addr / in_data      pooled activation memory (1-cycle read latency)
//   w_addr / w_data        class-major weight memory (1-cycle read latency)
//   b_addr / b_data        bias memory (1-cycle read latency)
//   out_we/out_addr/out_data  logit write port
//   sat_flag               sticky saturation indicator
// Optional feature: define FC_SAT_EN for saturating products and accumulation;
// without it arithmetic wraps modulo 2^DW and sat_flag stays 0.
module fc_sequencer #(
    parameter int N_IN   = 196,
    parameter int N_OUT  = 10,
    parameter int DW     = 16,
    parameter int IN_AW  = 8,
    parameter int W_AW   = 11,
    parameter int OUT_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IN_AW-1:0]  in_addr,
    input  logic [DW-1:0]     in_data,
    output logic [W_AW-1:0]   w_addr,
    input  logic [DW-1:0]     w_data,
    output logic [OUT_AW-1:0] b_addr,
    input  logic [DW-1:0]     b_data,
    output logic              out_we,
    output logic [OUT_AW-1:0] out_addr,
    output logic [DW-1:0]     out_data,
    output logic              sat_flag
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BIAS  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_TAIL  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [IN_AW-1:0]  J_LAST = IN_AW'(N_IN - 1);
    localparam logic [OUT_AW-1:0] I_LAST = OUT_AW'(N_OUT - 1);
    localparam logic [W_AW-1:0]   W_STEP = W_AW'(N_IN);
    logic [2:0]        state;
    logic [IN_AW-1:0]  j;
    logic [OUT_AW-1:0] i;
    logic [W_AW-1:0]   w_base;
    logic [DW-1:0]     acc;
    logic [DW-1:0]     acc_next;
    logic              clamp;
`ifdef FC_SAT_EN
    logic [2*DW-1:0] prod_full;
    logic [DW-1:0]   prod;
    logic [DW:0]     sum;
    always_comb begin
        prod_full = {{DW{1'b0}}, in_data} * {{DW{1'b0}}, w_data};
        prod      = |prod_full[2*DW-1:DW] ? '1 : prod_full[DW-1:0];
        sum       = {1'b0, acc} + {1'b0, prod};
        acc_next  = sum[DW] ? '1 : sum[DW-1:0];
        clamp     = |prod_full[2*DW-1:DW] | sum[DW];
    end
`else
    always_comb begin
        acc_next = acc + in_data * w_data;
        clamp    = 1'b0;
    end
`endif
    // Memory data lags its address by one cycle, so MAC step j consumes product j-1
    // and TAIL drains the last product straight into out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_addr  <= '0;
            w_addr   <= '0;
            b_addr   <= '0;
            out_we   <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
            sat_flag <= 1'b0;
            j        <= '0;
            i        <= '0;
            w_base   <= '0;
            acc      <= '0;
        end else begin
            out_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_BIAS;
                    busy     <= 1'b1;
                    i        <= '0;
                    b_addr   <= '0;
                    w_base   <= '0;
                    sat_flag <= 1'b0;
                end
                S_BIAS: begin
                    state   <= S_MAC;
                    j       <= '0;
                    in_addr <= '0;
                    w_addr  <= w_base;
                end
                S_MAC: begin
                    acc      <= j == '0 ? b_data : acc_next;
                    sat_flag <= sat_flag | (j != '0 && clamp);
                    if (j == J_LAST) begin
                        state <= S_TAIL;
                    end else begin
                        j       <= j + 1'b1;
                        in_addr <= j + 1'b1;
                        w_addr  <= w_addr + 1'b1;
                    end
                end
                S_TAIL: begin
                    state    <= S_WRITE;
                    acc      <= acc_next;
                    sat_flag <= sat_flag | clamp;
                    out_we   <= 1'b1;
                    out_addr <= i;
                    out_data <= acc_next;
                end
                S_WRITE: if (i == I_LAST) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end else begin
                    state  <= S_BIAS;
                    i      <= i + 1'b1;
                    b_addr <= i + 1'b1;
                    w_base <= w_base + W_STEP;
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    in_addr <= '0;
                    w_addr  <= '0;
                    b_addr  <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_sequencer.sv
// tb_fc_sequencer: model-checked bench for fc_sequencer (default and 4x2 configurations).
module tb_fc_sequencer;
    localparam int N = 196, M = 10, P = N + 3, T = M * P + 1;
    localparam int SN = 4, SM = 2;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, start_s = 1'b0;
    always #5 clk = ~clk;

    logic busy, done, out_we, sat_flag;
    logic [7:0] in_addr;
    logic [10:0] w_addr;
    logic [3:0] b_addr, out_addr;
    logic [15:0] in_data, w_data, b_data, out_data;
    logic [15:0] in_mem[256], w_mem[2048], b_mem[16];

    logic busy_s, done_s, out_we_s, sat_flag_s;
    logic [7:0] in_addr_s;
    logic [10:0] w_addr_s;
    logic [3:0] b_addr_s, out_addr_s;
    logic [15:0] in_data_s, w_data_s, b_data_s, out_data_s;
    logic [15:0] is_mem[256], ws_mem[2048], bs_mem[16];

    fc_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data), .out_we(out_we), .out_addr(out_addr),
        .out_data(out_data), .sat_flag(sat_flag)
    );
    fc_sequencer #(.N_IN(SN), .N_OUT(SM)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
        .in_addr(in_addr_s), .in_data(in_data_s), .w_addr(w_addr_s), .w_data(w_data_s),
        .b_addr(b_addr_s), .b_data(b_data_s), .out_we(out_we_s), .out_addr(out_addr_s),
        .out_data(out_data_s), .sat_flag(sat_flag_s)
    );

    always @(posedge clk) begin
        in_data   <= in_mem[in_addr];
        w_data    <= w_mem[w_addr];
        b_data    <= b_mem[b_addr];
        in_data_s <= is_mem[in_addr_s];
        w_data_s  <= ws_mem[w_addr_s];
        b_data_s  <= bs_mem[b_addr_s];
    end

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Logit i of the default instance straight from the arithmetic rules.
    function automatic logic [15:0] logit(input int i, output bit s);
        longint acc, p;
        acc = longint'(b_mem[i]);
        s = 1'b0;
        for (int j = 0; j < N; j++) begin
            p = longint'(in_mem[j]) * longint'(w_mem[i * N + j]);
`ifdef FC_SAT_EN
            if (p > 65535) begin p = 65535; s = 1'b1; end
            acc = acc + p;
            if (acc > 65535) begin acc = 65535; s = 1'b1; end
`else
            acc = (acc + p) % 65536;
`endif
        end
        return acc[15:0];
    endfunction

    // Model: run position m = edges since the accept edge.
    bit active = 1'b0, run_sat = 1'b0, msat = 1'b0, chk_en = 1'b0;
    int m = 0;
    logic [15:0] exp_l[M];
    always @(posedge clk) begin
        if (rst) begin
            active = 1'b0;
            msat = 1'b0;
        end else if (!active && start) begin
            bit s;
            active = 1'b1;
            m = 0;
            run_sat = 1'b0;
            for (int i = 0; i < M; i++) begin
                exp_l[i] = logit(i, s);
                run_sat |= s;
            end
        end else if (active) begin
            m++;
            if (m >= T) begin
                active = 1'b0;
                msat = run_sat;
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        bit we_exp;
        int ph, ci;
        we_exp = active && m < T - 1 && (m + 1) % P == 0;
        chk("busy", busy, active);
        chk("done", done, active && m == T - 1);
        chk("out_we", out_we, we_exp);
        if (we_exp) begin
            chk("out_addr", out_addr, (m + 1) / P - 1);
            chk("out_data", out_data, exp_l[(m + 1) / P - 1]);
        end
        if (active && m < T - 1) begin
            ph = m % P;
            ci = m / P;
            if (ph == 0) chk("b_addr", b_addr, ci);
            else if (ph <= N) begin
                chk("in_addr", in_addr, ph - 1);
                chk("w_addr", w_addr, ci * N + ph - 1);
            end
        end else if (!active) begin
            chk("idle_in_addr", in_addr, 0);
            chk("idle_w_addr", w_addr, 0);
            chk("idle_b_addr", b_addr, 0);
            chk("idle_sat", sat_flag, msat);
        end else begin
            chk("done_sat", sat_flag, run_sat);
        end
    end

    task automatic run_default(input bit pulses, input bit lit196);
        int k, nwe, dk;
        bit got;
        nwe = 0; dk = 0; got = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 1;
        chk("busy_after_accept", busy, 1);
        while (!got && k < 2100) begin
            if (out_we) begin
                nwe++;
                if (lit196) chk("lit_logit", {out_addr, out_data}, {4'(nwe - 1), 16'd196});
            end
            if (done) begin got = 1'b1; dk = k; end
            @(negedge clk);
            start = pulses && (k == 2 || k == 99);
            k++;
        end
        start = 1'b0;
        chk("done_cycle", dk, 1991);
        chk("write_count", nwe, 10);
        chk("busy_after_done", busy, 0);
    endtask

    int s_k[2], s_a[2], s_d[2], s_done, s_nwe;
    logic [10:0] s_wa[20];
    logic s_sat2, s_satd;
    task automatic run_small();
        s_nwe = 0; s_done = 0;
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        for (int k = 1; k < 20; k++) begin
            s_wa[k] = w_addr_s;
            if (k == 2) s_sat2 = sat_flag_s;
            if (out_we_s && s_nwe < 2) begin
                s_k[s_nwe] = k; s_a[s_nwe] = out_addr_s; s_d[s_nwe] = out_data_s;
                s_nwe++;
            end
            if (done_s) begin s_done = k; s_satd = sat_flag_s; end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin in_mem[a] = 0; is_mem[a] = 0; end
        for (int a = 0; a < 2048; a++) begin w_mem[a] = 0; ws_mem[a] = 0; end
        for (int a = 0; a < 16; a++) begin b_mem[a] = 0; bs_mem[a] = 0; end
        @(posedge clk);
        chk_en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            start = 1'($urandom);
            start_s = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_outs", {busy, done, out_we, sat_flag, in_addr, w_addr, b_addr, out_addr}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_small", {busy_s, done_s, out_we_s, sat_flag_s, in_addr_s, w_addr_s, b_addr_s, out_addr_s, out_data_s}, 0);
        rst = 1'b0; start = 1'b0; start_s = 1'b0;

        for (int a = 0; a < N; a++) in_mem[a] = 16'd1;
        for (int a = 0; a < N * M; a++) w_mem[a] = 16'd1;
        run_default(1'b1, 1'b1);

        for (int a = 0; a < N; a++) in_mem[a] = 16'($urandom);
        for (int a = 0; a < N * M; a++) w_mem[a] = 16'($urandom);
        for (int a = 0; a < M; a++) b_mem[a] = 16'($urandom);
        run_default(1'b0, 1'b0);

        begin
            int nwe;
            nwe = 0;
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            repeat (49) @(negedge clk);
            rst = 1'b1;
            @(negedge clk) rst = 1'b0;
            chk("abort_busy", busy, 0);
            repeat (300) begin
                nwe += int'(out_we);
                @(negedge clk);
            end
            chk("abort_no_we", nwe, 0);
        end
        run_default(1'b0, 1'b0);

        for (int a = 0; a < SN; a++) is_mem[a] = 16'(a + 1);
        for (int a = 0; a < SN; a++) ws_mem[a] = 16'd1;
        ws_mem[4] = 16'd2; ws_mem[5] = 16'd0; ws_mem[6] = 16'd0; ws_mem[7] = 16'd1;
        bs_mem[0] = 16'd10; bs_mem[1] = 16'd5;
        run_small();
        chk("s_writes", s_nwe, 2);
        chk("s_we0", {s_k[0][7:0], s_a[0][7:0], s_d[0][15:0]}, {8'd7, 8'd0, 16'd20});
        chk("s_we1", {s_k[1][7:0], s_a[1][7:0], s_d[1][15:0]}, {8'd14, 8'd1, 16'd11});
        chk("s_done", s_done, 15);
        chk("s_waddr", {s_wa[9], s_wa[10], s_wa[11], s_wa[12]}, {11'd4, 11'd5, 11'd6, 11'd7});
        chk("s_busy_end", busy_s, 0);

        for (int a = 0; a < SN; a++) is_mem[a] = 16'hFFFF;
        for (int a = 0; a < SN; a++) ws_mem[a] = 16'd1;
        for (int a = SN; a < 2 * SN; a++) ws_mem[a] = 16'd0;
        bs_mem[0] = 16'd1; bs_mem[1] = 16'd0;
        run_small();
`ifdef FC_SAT_EN
        chk("sat_logit", s_d[0], 16'hFFFF);
        chk("sat_flag", s_satd, 1);
        chk("sat_hold", sat_flag_s, 1);
`else
        chk("wrap_logit", s_d[0], 16'hFFFD);
        chk("sat_flag", s_satd, 0);
        chk("sat_hold", sat_flag_s, 0);
`endif
        for (int a = 0; a < SN; a++) is_mem[a] = 16'(a + 1);
        run_small();
        chk("sat_clear", s_sat2, 0);
        chk("sat_clear_done", s_satd, 0);
        chk("s_rerun", s_d[0], 16'd1 + 16'd10);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fc_sequencer.md
Name: fc_sequencer

Overview:
- Time-multiplexed controller for the fully-connected classifier layer.
- Replaces the single-cycle, 1960-multiplier array with one 16x16 MAC.
- Reads pooled activations, weights and biases from synchronous-read memories. Writes each logit to an output buffer.
- Sits between the pooling stage's output buffer and the argmax/result stage. Driven by a start/busy/done handshake from the top-level network controller.

Parameters:
- N_IN, 196, activations per class (flattened 14x14 pooled map).
- N_OUT, 10, number of classes/logits.
- DW, 16, data width of activations, weights, biases and logits.
- IN_AW, 8, activation address width (>= clog2(N_IN)).
- W_AW, 11, weight address width (>= clog2(N_IN*N_OUT)).
- OUT_AW, 4, class/bias/output address width (>= clog2(N_OUT)).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle pulse when all N_OUT logits are written.
- in_addr  out  IN_AW  activation read address.
- in_data  in  DW  activation read data, valid the cycle after in_addr.
- w_addr  out  W_AW  weight read address (class-major: i*N_IN+j).
- w_data  in  DW  weight read data, valid the cycle after w_addr.
- b_addr  out  OUT_AW  bias read address.
- b_data  in  DW  bias read data, valid the cycle after b_addr.
- out_we  out  1  logit write strobe.
- out_addr  out  OUT_AW  logit index i.
- out_data  out  DW  logit value.
- sat_flag  out  1  sticky saturation indicator; constant 0 unless FC_SAT_EN.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset: all outputs 0 (busy, done, out_we, sat_flag, all addresses, out_data), state IDLE, accumulator 0, counters 0.
- Reset mid-run: run aborts immediately. No further out_we. Logits already written are left as-is in the external buffer.
- All outputs are registered.
- States: IDLE, BIAS, MAC, TAIL, WRITE, DONE.
- IDLE: addresses held at 0. On start=1 go to BIAS with i=0 and clear sat_flag.
- BIAS (1 cycle): b_addr=i. Then MAC with j=0.
- MAC (N_IN cycles): in_addr=j, w_addr=i*N_IN+j.
  - At j=0: acc <= b_data.
  - At j>=1: acc <= acc + product(j-1).
  - After j=N_IN-1 go to TAIL.
- TAIL (1 cycle): acc <= acc + product(N_IN-1).
- WRITE (1 cycle): out_we=1, out_addr=i, out_data=acc. If i=N_OUT-1 go to DONE; else i<=i+1 and go to BIAS.
- DONE (1 cycle): done=1, busy=1. Then IDLE with busy=0.
- Arithmetic: product = in_data*w_data truncated to the low DW bits. Accumulate modulo 2^DW, unsigned.
- Timing:
  - Cycles per class = N_IN+3.
  - done is high exactly N_OUT*(N_IN+3)+1 cycles after the start-accept edge; 1991 for defaults.
  - Earliest next accept is the cycle after DONE.
- Start while busy (any non-IDLE state, including DONE): ignored, no side effects.
- Start held high continuously: a new run begins on each return to IDLE.
- Input/weight data is sampled only in the cycle after its address. Memory contents must stay static during a run.

Optional Feature:
- Macro FC_SAT_EN.
- Defined:
  - Product clamps to 2^DW-1 if the full 2*DW product exceeds it.
  - Each accumulate clamps at 2^DW-1.
  - Bias load is never clamped.
  - Any clamp sets sat_flag. sat_flag stays set until the next start is accepted, or rst.
- Undefined: wrap-around arithmetic as above, and sat_flag is tied to 0.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> every output 0, state IDLE. A start one cycle after rst release is accepted.
- N_IN=4, N_OUT=2; in=[1,2,3,4], w0=[1,1,1,1], w1=[2,0,0,1], b=[10,5] ->
  - writes (0,20) and (1,11);
  - out_we at cycles 7 and 14 after accept;
  - done at cycle 15;
  - w_addr in class-1 MAC = 4,5,6,7.
- Defaults, all in=1, w=1, b=0 -> ten writes of 196 at addresses 0..9; done exactly 1991 cycles after accept; busy low the next cycle.
- N_IN=4, N_OUT=1, in=0xFFFF, w=1, b=1:
  - without FC_SAT_EN -> out_data=0xFFFD, sat_flag=0;
  - with FC_SAT_EN -> 0xFFFF, sat_flag=1 until the next start.
- Pulse start again at cycles 3 and 100 of a default run -> ignored; exactly 10 writes and one done.
- Assert rst at cycle 50 of a run -> next cycle busy=0, out_we never rises. A fresh start then completes normally with correct logits.
